acc_drain: RTL and testbench

//   Inverse of the accumulator datapath: repeated-subtraction unsigned divider.

---
 rtl/acc_drain.sv | 113 +++++++++++
 tb/tb_acc_drain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain.sv
// acc_drain: repeated-subtraction unsigned divider.
// Latches a dividend and a divisor on start, then removes one divisor from
// the running residue per clock. The number of removals becomes the quotient
// and the final residue becomes the remainder. A zero divisor skips the
// drain and reports err with an all-ones quotient.
module acc_drain #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,      // active-high asynchronous reset
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] r;          // running residue
   logic [WIDTH-1:0] d;          // latched step size
   logic             can_sub;

   // Because subtraction only happens while r >= d, r - d never underflows.
   assign can_sub = (r >= d);

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A zero divisor bypasses BUSY and goes straight to DONE.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = (divisor == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (!can_sub) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with the state.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (next_state == BUSY);
         done <= (next_state == DONE);
      end
   end

   // Operand latch, drain loop and result registers.
   // Results hold through DONE and IDLE until the next accepted start.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r         <= '0;
         d         <= '0;
         quotient  <= '0;
         remainder <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  r        <= dividend;
                  d        <= divisor;
                  quotient <= '0;
                  err      <= 1'b0;
                  if (divisor == '0) begin
                     err       <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end
               end
            end
            BUSY: begin
               if (can_sub) begin
                  r        <= r - d;
                  quotient <= quotient + WIDTH'(1);
               end else begin
                  remainder <= r;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_drain.sv
// Testbench for acc_drain: directed scenarios plus randomized operations
// checked against a plain divide/modulo reference model.
module tb_acc_drain;

   localparam int WIDTH = 4;
   localparam int MAX_WAIT = 40;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   int tests_run;
   int tests_failed;

   acc_drain #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .quotient  (quotient),
      .remainder (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one operation and observes it until done, or until the wait bound runs out.
   // lat is the number of edges after the start edge at which done was seen (-1 on timeout).
   // busy_bad counts cycles where busy disagreed with the reference timeline.
   // With noise set, start/dividend/divisor toggle randomly while the op is in flight.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noise,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] rm, output logic e,
                         output int lat, output int busy_bad,
                         output logic post_done, output logic post_busy,
                         output logic [WIDTH-1:0] post_q, output logic [WIDTH-1:0] post_r);
      int  n;
      int  k;
      bit  exp_busy;
      k = (b == 0) ? -1 : int'(a) / int'(b);
      busy_bad = 0;
      lat = -1;
      q = '0; rm = '0; e = 1'b0;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      n = 0;
      forever begin
         exp_busy = (b != 0) && (n <= k);
         if (busy !== exp_busy) busy_bad++;
         if (done === 1'b1) begin
            lat = n; q = quotient; rm = remainder; e = err;
            start = 1'b0;
            break;
         end
         if (n >= MAX_WAIT) break;
         if (noise && (b != 0) && (n <= k)) begin
            start = 1'($urandom_range(0, 1));
            dividend = 4'($urandom); divisor = 4'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      @(posedge clk); #1;
      post_done = done; post_busy = busy; post_q = quotient; post_r = remainder;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      tests_run++;
      if ({busy, done, err, quotient, remainder} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b q=%0d r=%0d want all 0",
                  busy, done, err, quotient, remainder);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({busy, done} !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   // Runs one operation and checks it against a/b, a%b (or the divide-by-zero rule).
   task automatic test_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit noise);
      logic [WIDTH-1:0] q, rm, pq, pr, eq, er;
      logic             e, pd, pb, ee;
      int               lat, bb, elat;
      if (b == 0) begin
         eq = '1; er = a; ee = 1'b1; elat = 0;
      end else begin
         eq = WIDTH'(int'(a) / int'(b)); er = WIDTH'(int'(a) % int'(b)); ee = 1'b0;
         elat = int'(a) / int'(b) + 1;
      end
      run_op(a, b, noise, q, rm, e, lat, bb, pd, pb, pq, pr);
      tests_run++;
      if (lat !== elat) begin
         tests_failed++;
         $display("FAIL %s latency %0d/%0d got %0d edges want %0d", name, a, b, lat, elat);
      end
      tests_run++;
      if ({q, rm, e} !== {eq, er, ee}) begin
         tests_failed++;
         $display("FAIL %s result %0d/%0d got q=%0d r=%0d err=%b want q=%0d r=%0d err=%b",
                  name, a, b, q, rm, e, eq, er, ee);
      end
      tests_run++;
      if (bb != 0) begin
         tests_failed++;
         $display("FAIL %s busy_timeline %0d/%0d got %0d bad cycles want 0", name, a, b, bb);
      end
      tests_run++;
      if ({pd, pb, pq, pr} !== {1'b0, 1'b0, eq, er}) begin
         tests_failed++;
         $display("FAIL %s after_done got done=%b busy=%b q=%0d r=%0d want done=0 busy=0 q=%0d r=%0d",
                  name, pd, pb, pq, pr, eq, er);
      end
   endtask

   task automatic test_div_zero_then_clear();
      test_op("div0", 4'd7, 4'd0, 1'b0);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL div0_err_hold got err=%b want 1", err);
      end
      test_op("after_div0", 4'd6, 4'd2, 1'b0);
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_cleared got err=%b want 0", err);
      end
   endtask

   task automatic test_start_while_busy();
      logic [WIDTH-1:0] q, rm, pq, pr;
      logic             e, pd, pb;
      int               lat, bb;
      fork
         run_op(4'd14, 4'd3, 1'b0, q, rm, e, lat, bb, pd, pb, pq, pr);
         begin
            @(posedge clk); @(posedge clk); #2;
            start = 1'b1; dividend = 4'd9; divisor = 4'd9;
            @(posedge clk); #2;
            start = 1'b0;
         end
      join
      tests_run++;
      if ({q, rm, e, lat} !== {4'd4, 4'd2, 1'b0, 5}) begin
         tests_failed++;
         $display("FAIL start_in_busy got q=%0d r=%0d err=%b lat=%0d want q=4 r=2 err=0 lat=5",
                  q, rm, e, lat);
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      start = 1'b1; dividend = 4'd15; divisor = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_before_reset got %b want 1", busy);
      end
      #2 rst_n = 1'b1;
      #1;
      tests_run++;
      if ({busy, done, err, quotient, remainder} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset got busy=%b done=%b err=%b q=%0d r=%0d want all 0",
                  busy, done, err, quotient, remainder);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      test_op("after_reset", 4'd5, 4'd2, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         test_op("random", 4'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_op("basic", 4'd13, 4'd3, 1'b0);
      test_op("zero_dividend", 4'd0, 4'd5, 1'b0);
      test_op("max_quotient", 4'd15, 4'd1, 1'b0);
      test_op("equal", 4'd9, 4'd9, 1'b0);
      test_op("small_over_big", 4'd3, 4'd15, 1'b0);
      test_div_zero_then_clear();
      test_start_while_busy();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
